// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional two-entry skid buffer.
// Bubbles zero their control payload; flush and hold act on the whole stage.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              has_skid;
  logic              accept;
  logic              transfer;

  assign has_skid = (SKID != 0);

  assign dn_valid = m_valid & ~hold;
  assign dn_data  = m_data;
  assign dn_ctrl  = dn_valid ? m_ctrl : '0;

  // With a skid entry, ready depends only on registered state.
  assign up_ready = (has_skid ? ~s_valid : (~m_valid | dn_ready))
                  & ~hold & ~flush;

  assign accept   = up_valid & up_ready;
  assign transfer = dn_valid & dn_ready;

  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end else if (transfer && s_valid) begin
      m_data  <= s_data;
      m_ctrl  <= s_ctrl;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
    end else if (accept && (!m_valid || transfer)) begin
      m_valid <= 1'b1;
      m_data  <= up_data;
      m_ctrl  <= up_ctrl;
    end else if (accept && has_skid) begin
      s_valid <= 1'b1;
      s_data  <= up_data;
      s_ctrl  <= up_ctrl;
    end else if (transfer) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
    end
  end

endmodule
